// File: rtl/puf_challenge_feeder.sv
// Challenge feeder for the two-round diffusion network: builds an N_CB-bit challenge
// from serial words or a Galois LFSR, holds it for SETTLE cycles, strobes evaluate, waits for ack.
module puf_challenge_feeder #(
  parameter int              N_CB   = 64,
  parameter int              W_IN   = 8,
  parameter int              SETTLE = 4,
  parameter logic [N_CB-1:0] TAPS   = 64'hD800000000000000,
  parameter logic [N_CB-1:0] SEED   = 64'h1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            start,
  input  logic [W_IN-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [N_CB-1:0] B,
  output logic            b_valid,
  output logic            eval_pulse,
  input  logic            resp_ack,
  output logic            busy,
  output logic [15:0]     chal_cnt,
  output logic [2:0]      o_dbg_state
);

  localparam int N_WORDS = N_CB / W_IN;
  localparam int KW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_GEN      = 3'd2,
    S_SETTLE   = 3'd3,
    S_EVAL     = 3'd4,
    S_WAIT_ACK = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [N_CB-1:0] r_shadow;
  logic [N_CB-1:0] r_b;
  logic [N_CB-1:0] r_lfsr;
  logic [KW-1:0]   r_word_cnt;
  logic [7:0]      r_settle_cnt;
  logic [15:0]     r_chal_cnt;

  logic            w_load_start;
  logic            w_accept;
  logic            w_last_word;
  logic            w_load_done;
  logic            w_gen;
  logic            w_settle_done;
  logic            w_ack;
  logic [N_CB-1:0] w_shadow_upd;
  logic [N_CB-1:0] w_lfsr_next;

  // Handshake: a serial word is taken on any cycle where din_valid and din_ready are both
  // high; din_ready is asserted only in LOAD, so din_valid elsewhere is simply ignored.
  always_comb begin
    w_load_start  = 1'b0;
    w_accept      = 1'b0;
    w_last_word   = 1'b0;
    w_load_done   = 1'b0;
    w_gen         = 1'b0;
    w_settle_done = 1'b0;
    w_ack         = 1'b0;
    w_next_state  = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode) begin
            w_next_state = S_GEN;
          end else begin
            w_load_start = 1'b1;
            w_next_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_accept    = din_valid;
        w_last_word = (r_word_cnt == KW'(N_WORDS - 1));
        if (w_accept && w_last_word) begin
          w_load_done  = 1'b1;
          w_next_state = S_SETTLE;
        end
      end
      S_GEN: begin
        w_gen        = 1'b1;
        w_next_state = S_SETTLE;
      end
      S_SETTLE: begin
        w_settle_done = (r_settle_cnt == 8'(SETTLE - 1));
        if (w_settle_done) begin
          w_next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (resp_ack) begin
          w_ack        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The final word is merged here so B picks up the complete challenge on the last accept.
  always_comb begin
    w_shadow_upd = r_shadow;
    w_shadow_upd[r_word_cnt * W_IN +: W_IN] = din;
  end

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_b          <= '0;
      r_lfsr       <= SEED;
      r_word_cnt   <= '0;
      r_settle_cnt <= '0;
      r_chal_cnt   <= '0;
    end else begin
      if (w_load_start) begin
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_shadow   <= w_shadow_upd;
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
      end
      if (w_load_done) begin
        r_b <= w_shadow_upd;
      end else if (w_gen) begin
        r_lfsr <= w_lfsr_next;
        r_b    <= w_lfsr_next;
      end
      // Counter is zero everywhere outside SETTLE, so each SETTLE visit starts from 0.
      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 8'd1 : 8'd0;
      if (w_ack) begin
        r_chal_cnt <= r_chal_cnt + 16'd1;
      end
    end
  end

  assign din_ready   = (r_state == S_LOAD);
  assign b_valid     = (r_state == S_SETTLE) || (r_state == S_EVAL) || (r_state == S_WAIT_ACK);
  assign eval_pulse  = (r_state == S_EVAL);
  assign busy        = (r_state != S_IDLE);
  assign B           = r_b;
  assign chal_cnt    = r_chal_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_puf_challenge_feeder.sv
// Randomised bench for puf_challenge_feeder: driver tasks script each transaction and
// publish the per-cycle expected outputs; one negedge process compares the DUT against them.
module tb_puf_challenge_feeder;

  localparam int          N_CB   = 64;
  localparam int          W_IN   = 8;
  localparam int          SETTLE = 4;
  localparam logic [63:0] TAPS   = 64'hD800000000000000;
  localparam logic [63:0] SEED   = 64'h1;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] B;
  logic        b_valid;
  logic        eval_pulse;
  logic        resp_ack;
  logic        busy;
  logic [15:0] chal_cnt;
  logic [2:0]  dbg_state;

  puf_challenge_feeder #(
    .N_CB(N_CB), .W_IN(W_IN), .SETTLE(SETTLE), .TAPS(TAPS), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .B(B), .b_valid(b_valid), .eval_pulse(eval_pulse),
    .resp_ack(resp_ack), .busy(busy), .chal_cnt(chal_cnt),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic [63:0] m_lfsr;
  logic [63:0] m_b;
  logic [15:0] m_cnt;
  logic [7:0]  words [8];

  // per-cycle expectations
  logic [63:0] exp_b;
  logic        exp_bv;
  logic        exp_ev;
  logic        exp_dr;
  logic        exp_busy;
  logic [15:0] exp_cnt;
  logic        chk_en;

  int n_pass;
  int n_total;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [63:0] assemble();
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) acc = acc | (64'(words[k]) << (8 * k));
    return acc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("B", B, exp_b);
      chk("b_valid", 64'(b_valid), 64'(exp_bv));
      chk("eval_pulse", 64'(eval_pulse), 64'(exp_ev));
      chk("din_ready", 64'(din_ready), 64'(exp_dr));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("chal_cnt", 64'(chal_cnt), 64'(exp_cnt));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit bv, input bit ev, input bit dr, input bit bz);
    exp_bv   = bv;
    exp_ev   = ev;
    exp_dr   = dr;
    exp_busy = bz;
    exp_b    = m_b;
    exp_cnt  = m_cnt;
  endtask

  task automatic noise(input bit rnd_start, input bit rnd_ack);
    start     = rnd_start ? 1'($urandom) : 1'b0;
    mode      = 1'($urandom);
    din       = 8'($urandom);
    din_valid = 1'($urandom);
    resp_ack  = rnd_ack ? 1'($urandom) : 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      set_exp(0, 0, 0, 0);
      noise(0, 1);
    end
  endtask

  // SETTLE, EVAL and WAIT_ACK, ending in the ack cycle
  task automatic run_tail();
    int nw;
    for (int i = 0; i < SETTLE; i++) begin
      cyc();
      set_exp(1, 0, 0, 1);
      noise(1, 1);
    end
    cyc();
    set_exp(1, 1, 0, 1);
    noise(1, 1);
    nw = $urandom_range(0, 3);
    for (int i = 0; i < nw; i++) begin
      cyc();
      set_exp(1, 0, 0, 1);
      noise(1, 0);
    end
    cyc();
    set_exp(1, 0, 0, 1);
    noise(1, 0);
    resp_ack = 1'b1;
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic run_gen();
    cyc();
    set_exp(0, 0, 0, 0);
    noise(0, 1);
    start = 1'b1;
    mode  = 1'b1;
    cyc();
    set_exp(0, 0, 0, 1);
    noise(1, 1);
    m_lfsr = lfsr_step(m_lfsr);
    m_b    = m_lfsr;
    run_tail();
  endtask

  // gap < 0 picks a random 0..2 cycle stall before each word
  task automatic run_load(input int gap);
    int g;
    cyc();
    set_exp(0, 0, 0, 0);
    noise(0, 1);
    start = 1'b1;
    mode  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      g = (gap >= 0) ? gap : $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        cyc();
        set_exp(0, 0, 1, 1);
        noise(1, 1);
        din_valid = 1'b0;
      end
      cyc();
      set_exp(0, 0, 1, 1);
      noise(1, 1);
      din_valid = 1'b1;
      din       = words[k];
    end
    m_b = assemble();
    run_tail();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    mode    = 1'b0;
    start   = 1'b0;
    din     = '0;
    din_valid = 1'b0;
    resp_ack  = 1'b0;
    m_lfsr  = SEED;
    m_b     = '0;
    m_cnt   = '0;
    set_exp(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    chk("rst_B", B, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(chal_cnt), 64'h0);
    chk_en = 1'b1;

    // external load 01..08, back-to-back valid
    for (int k = 0; k < 8; k++) words[k] = 8'(k + 1);
    run_load(0);
    chk("load_literal", B, 64'h0807060504030201);
    idle_gap(1);
    chk("cnt_after_load", 64'(chal_cnt), 64'h1);

    // asynchronous reset in the middle of SETTLE
    cyc();
    set_exp(0, 0, 0, 0);
    noise(0, 1);
    start = 1'b1;
    mode  = 1'b1;
    cyc();
    set_exp(0, 0, 0, 1);
    noise(1, 1);
    m_b = lfsr_step(m_lfsr);
    for (int i = 0; i < 2; i++) begin
      cyc();
      set_exp(1, 0, 0, 1);
      noise(1, 1);
    end
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_B", B, 64'h0);
    chk("arst_b_valid", 64'(b_valid), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_cnt", 64'(chal_cnt), 64'h0);
    start = 1'b0;
    din_valid = 1'b0;
    resp_ack = 1'b0;
    m_lfsr = SEED;
    m_b    = '0;
    m_cnt  = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    set_exp(0, 0, 0, 0);
    chk_en = 1'b1;

    // LFSR sequence from SEED
    run_gen();
    chk("lfsr_1", B, 64'hD800000000000000);
    run_gen();
    chk("lfsr_2", B, 64'h6C00000000000000);
    run_gen();
    chk("lfsr_3", B, 64'h3600000000000000);
    idle_gap(1);
    chk("cnt_3", 64'(chal_cnt), 64'h3);

    // mode toggles during the challenge; then a stalled load must leave the LFSR alone
    run_gen();
    chk("lfsr_4", B, 64'h1B00000000000000);
    idle_gap(1);
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    run_load(3);
    idle_gap(2);
    run_gen();
    chk("lfsr_after_load", B, 64'h0D80000000000000);

    // randomised mix
    for (int t = 0; t < 40; t++) begin
      idle_gap($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        run_gen();
      end else begin
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        run_load(-1);
      end
    end

    // challenge counter wrap, preloaded through the back door
    idle_gap(1);
    force dut.r_chal_cnt = 16'hFFFE;
    #1;
    release dut.r_chal_cnt;
    m_cnt   = 16'hFFFE;
    exp_cnt = m_cnt;
    run_gen();
    idle_gap(1);
    chk("cnt_ffff", 64'(chal_cnt), 64'hFFFF);
    run_gen();
    idle_gap(1);
    chk("cnt_wrap", 64'(chal_cnt), 64'h0);
    idle_gap(2);

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
